// File: rtl/receiver_pkg.sv
// Shared definitions for the RS232 receive-to-memory writer: state encodings and
// default sizing constants.
package receiver_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    WAIT_BYTE = 2'b01,
    WRITE     = 2'b10,
    DONE      = 2'b11
  } rx_state_t;

  localparam int unsigned ADDR_W_DEF         = 16;
  localparam int unsigned TIMEOUT_CYCLES_DEF = 50000;

endpackage

// File: rtl/rx_timeout_counter.sv
// Idle-gap counter for the receive writer: counts enabled cycles and pulses
// expired on the cycle the count reaches LIMIT-1.
module rx_timeout_counter #(
  parameter int unsigned LIMIT = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CNT_W = (LIMIT > 2) ? $clog2(LIMIT) : 1;

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      if (count == CNT_W'(LIMIT - 1)) count <= '0;
      else                            count <= count + 1'b1;
    end
  end

  assign expired = enable && !clear && (count == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/receiver_writer.sv
// Receive end of the RS232 sample link: writes each UART byte to sample memory at
// consecutive addresses. Optional inter-byte timeout enabled by macro RX_TIMEOUT_EN.
module receiver_writer
  import receiver_pkg::*;
#(
  parameter int unsigned ADDR_W         = ADDR_W_DEF,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic              iClock,
  input  logic              iReset_n,
  input  logic              iStart,
  input  logic [7:0]        iRxData,
  input  logic              iRxDone,
  output logic [ADDR_W-1:0] oAddress,
  output logic [7:0]        oData,
  output logic              oWriteEnable,
  output logic              oBusy,
  output logic              oReceiveFinished,
  output logic              oOverrun,
  output logic              oTimeout
);

  rx_state_t state, state_next;
  logic      expired;
  logic      last_addr;

  assign last_addr = &oAddress;
  assign oBusy     = (state != IDLE);

`ifdef RX_TIMEOUT_EN
  logic to_clear, to_enable;

  // The gap timer only runs between bytes, never before the first one arrives.
  assign to_clear  = iRxDone || (state != WAIT_BYTE);
  assign to_enable = (state == WAIT_BYTE) && (oAddress != '0);

  rx_timeout_counter #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (iClock),
    .rst_n   (iReset_n),
    .clear   (to_clear),
    .enable  (to_enable),
    .expired (expired)
  );
`else
  logic unused_timeout_cfg;

  assign expired            = 1'b0;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
`endif

  always_comb begin
    state_next = state;
    case (state)
      IDLE:      if (iStart) state_next = WAIT_BYTE;
      WAIT_BYTE: begin
        if (iRxDone)      state_next = WRITE;
        else if (expired) state_next = IDLE;
      end
      WRITE:     state_next = last_addr ? DONE : WAIT_BYTE;
      DONE:      state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  always_ff @(posedge iClock or negedge iReset_n) begin
    if (!iReset_n) begin
      state            <= IDLE;
      oAddress         <= '0;
      oData            <= '0;
      oWriteEnable     <= 1'b0;
      oReceiveFinished <= 1'b0;
      oOverrun         <= 1'b0;
      oTimeout         <= 1'b0;
    end else begin
      state            <= state_next;
      oWriteEnable     <= 1'b0;
      oReceiveFinished <= 1'b0;
      oTimeout         <= 1'b0;
      case (state)
        IDLE: begin
          if (iStart) begin
            oAddress <= '0;
            oOverrun <= 1'b0;
          end
        end
        WAIT_BYTE: begin
          if (iRxDone) begin
            oData        <= iRxData;
            oWriteEnable <= 1'b1;
          end else if (expired) begin
            oTimeout <= 1'b1;
            oAddress <= '0;
          end
        end
        WRITE: begin
          // A byte landing during the write cycle cannot be stored; flag and drop it.
          if (iRxDone) oOverrun <= 1'b1;
          if (last_addr) oAddress <= '0;
          else           oAddress <= oAddress + 1'b1;
        end
        DONE: oReceiveFinished <= 1'b1;
        default: ;
      endcase
    end
  end

endmodule
